// File: rtl/timer_pkg.sv
// Shared constants and helpers for the BCD timer digit chain.
// Moduli are 4-bit codes, 4'hA meaning ten.
package timer_pkg;

  localparam int DIGIT_W       = 4;
  localparam int MOD_SEC_TENS  = 6;
  localparam int MOD_DEC       = 10;
  localparam int MOD_HOUR_TENS = 3;

  localparam logic [15:0] MMSS_MODS = 16'h6A6A;

  function automatic logic [3:0] clamp_digit(
    input logic [3:0] d,
    input logic [3:0] m
  );
    return (d >= m) ? m - 4'd1 : d;
  endfunction

endpackage

// File: rtl/bcd_digit_modn.sv
// One mod-N BCD digit with clear, clamped load and up/down step.
// Priority: clear, then load, then step.
module bcd_digit_modn
  import timer_pkg::*;
(
  input  logic         clk,
  input  logic         clear,
  input  logic         loadn,
  input  logic [3:0]   data,
  input  logic         en,
  input  logic         up,
  input  logic [3:0]   mod,
  output logic [3:0]   value,
  output logic         at_min,
  output logic         at_max
);

  logic [3:0] q;

  assign value  = q;
  assign at_min = (q == 4'd0);
  assign at_max = (q == mod - 4'd1);

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= 4'd0;
    end else if (!loadn) begin
      q <= clamp_digit(data, mod);
    end else if (en) begin
      if (up)
        q <= at_max ? 4'd0 : q + 4'd1;
      else
        q <= at_min ? mod - 4'd1 : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_timer_chain.sv
// Cascade of mod-N BCD digits with ripple carry/borrow,
// stop-or-wrap at terminal, and a registered done pulse.
module bcd_timer_chain
  import timer_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter logic [DIGIT_W*NUM_DIGITS-1:0]
    MOD_PACKED = MMSS_MODS,
  parameter bit WRAP_MODE = 1'b0
) (
  input  logic                          clk,
  input  logic                          clear,
  input  logic                          loadn,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] data,
  input  logic                          en,
  input  logic                          up,
  output logic [DIGIT_W*NUM_DIGITS-1:0] count,
  output logic                          zero,
  output logic                          tc,
  output logic                          done
);

  localparam int N = NUM_DIGITS;

  logic [N-1:0] at_min;
  logic [N-1:0] at_max;
  logic [N-1:0] chain_up;
  logic [N-1:0] chain_dn;
  logic [N-1:0] dig_en;
  logic         term;
  logic         step;
  logic         lands_up;
  logic         lands_dn;
  logic         done_d;
  logic [3:0]   mod0;
  logic [3:0]   val0;

  assign chain_up[0] = 1'b1;
  assign chain_dn[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_dig
      if (i > 0) begin : g_chain
        assign chain_up[i] =
          chain_up[i-1] & at_max[i-1];
        assign chain_dn[i] =
          chain_dn[i-1] & at_min[i-1];
      end
      assign dig_en[i] = step &
        (up ? chain_up[i] : chain_dn[i]);
      bcd_digit_modn u_dig (
        .clk    (clk),
        .clear  (clear),
        .loadn  (loadn),
        .data   (data[4*i +: 4]),
        .en     (dig_en[i]),
        .up     (up),
        .mod    (MOD_PACKED[4*i +: 4]),
        .value  (count[4*i +: 4]),
        .at_min (at_min[i]),
        .at_max (at_max[i])
      );
    end
  endgenerate

  assign term = up ? (&at_max) : (&at_min);
  assign zero = &at_min;
  assign tc   = en & term;
  assign step = en & ~(term & ~WRAP_MODE);
  assign mod0 = MOD_PACKED[3:0];
  assign val0 = count[3:0];

  // Will this step land exactly on the terminal value?
  always_comb begin
    lands_up = (val0 == mod0 - 4'd2);
    lands_dn = (val0 == 4'd1);
    for (int k = 1; k < N; k++) begin
      lands_up = lands_up & at_max[k];
      lands_dn = lands_dn & at_min[k];
    end
  end

  // Wrapping chains pulse on rollover; stopping
  // chains pulse on arrival at the terminal.
  always_comb begin
    done_d = 1'b0;
    if (step) begin
      if (WRAP_MODE)
        done_d = term;
      else
        done_d = up ? lands_up : lands_dn;
    end
  end

  always_ff @(posedge clk) begin
    if (clear)
      done <= 1'b0;
    else if (!loadn)
      done <= 1'b0;
    else
      done <= done_d;
  end

endmodule

// File: tb/tb_bcd_timer_chain.sv
// Bench for bcd_timer_chain: three parameterisations
// checked against a mixed-radix integer model.
module tb_bcd_timer_chain;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        loadn = 1'b1;
  logic [15:0] data = 16'h0;
  logic        en = 1'b0;
  logic        up = 1'b0;

  logic [15:0] c0, c1;
  logic [7:0]  c2;
  logic [2:0]  zr, tcs, dn;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_timer_chain u0 (
    .clk(clk), .clear(clear), .loadn(loadn),
    .data(data), .en(en), .up(up), .count(c0),
    .zero(zr[0]), .tc(tcs[0]), .done(dn[0]));

  bcd_timer_chain #(.WRAP_MODE(1'b1)) u1 (
    .clk(clk), .clear(clear), .loadn(loadn),
    .data(data), .en(en), .up(up), .count(c1),
    .zero(zr[1]), .tc(tcs[1]), .done(dn[1]));

  bcd_timer_chain #(
    .NUM_DIGITS(2), .MOD_PACKED(8'hAA),
    .WRAP_MODE(1'b0)) u2 (
    .clk(clk), .clear(clear), .loadn(loadn),
    .data(data[7:0]), .en(en), .up(up), .count(c2),
    .zero(zr[2]), .tc(tcs[2]), .done(dn[2]));

  // Model: each chain is one integer in a mixed radix.
  int          nd[3]   = '{4, 4, 2};
  bit [31:0]   mods[3] = '{32'h6A6A, 32'h6A6A, 32'hAA};
  bit          wr[3]   = '{1'b0, 1'b1, 1'b0};
  int          mv[3];
  bit          mdone[3];

  function automatic int maxv(int k);
    int p = 1;
    for (int i = 0; i < nd[k]; i++)
      p = p * int'((mods[k] >> (4*i)) & 32'hF);
    return p - 1;
  endfunction

  function automatic int to_val(int k, bit [31:0] d);
    int v = 0;
    for (int i = nd[k]-1; i >= 0; i--) begin
      int m = int'((mods[k] >> (4*i)) & 32'hF);
      int x = int'((d >> (4*i)) & 32'hF);
      if (x >= m) x = m - 1;
      v = v * m + x;
    end
    return v;
  endfunction

  function automatic bit [31:0] to_bcd(int k, int v);
    bit [31:0] r = 0;
    int t = v;
    for (int i = 0; i < nd[k]; i++) begin
      int m = int'((mods[k] >> (4*i)) & 32'hF);
      r = r | (bit'(1) ? (32'(t % m) << (4*i)) : 0);
      t = t / m;
    end
    return r;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int mx = maxv(k);
      if (clear) begin
        mv[k] = 0; mdone[k] = 0;
      end else if (!loadn) begin
        mv[k] = to_val(k, 32'(data)); mdone[k] = 0;
      end else if (en) begin
        bit t = up ? (mv[k] == mx) : (mv[k] == 0);
        if (t && !wr[k]) begin
          mdone[k] = 0;
        end else begin
          int nv;
          if (up) nv = t ? 0 : mv[k] + 1;
          else    nv = t ? mx : mv[k] - 1;
          if (wr[k]) mdone[k] = t;
          else mdone[k] = up ? (nv == mx) : (nv == 0);
          mv[k] = nv;
        end
      end else begin
        mdone[k] = 0;
      end
    end
  endtask

  task automatic chk(string nm, bit [31:0] act,
                     bit [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_model();
    bit [31:0] act;
    for (int k = 0; k < 3; k++) begin
      int mx = maxv(k);
      bit t = up ? (mv[k] == mx) : (mv[k] == 0);
      act = (k == 0) ? 32'(c0) :
            (k == 1) ? 32'(c1) : 32'(c2);
      chk($sformatf("u%0d.count", k), act,
          to_bcd(k, mv[k]));
      chk($sformatf("u%0d.done", k),
          32'(dn[k]), 32'(mdone[k]));
      chk($sformatf("u%0d.zero", k),
          32'(zr[k]), 32'(mv[k] == 0));
      chk($sformatf("u%0d.tc", k),
          32'(tcs[k]), 32'(en & t));
    end
  endtask

  task automatic cyc(bit cl, bit ld, bit [15:0] d,
                     bit e, bit u);
    clear = cl; loadn = ld; data = d; en = e; up = u;
    model_step();
    @(posedge clk);
    #1;
    chk_model();
  endtask

  typedef struct {
    bit        cl;
    bit        ld;
    bit [15:0] d;
    bit        e;
    bit        u;
    bit [15:0] exp;
    bit        exp_done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit cl, bit ld,
    bit [15:0] d, bit e, bit u, bit [15:0] x, bit xd);
    vec_t v;
    v.cl = cl; v.ld = ld; v.d = d; v.e = e; v.u = u;
    v.exp = x; v.exp_done = xd;
    return v;
  endfunction

  initial begin
    tbl.push_back(mk(1, 1, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 16'h0000, 1, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 16'hFF9F, 0, 0, 16'h5959, 0));
    tbl.push_back(mk(1, 0, 16'h1234, 1, 1, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 16'h0010, 0, 0, 16'h0010, 0));
    tbl.push_back(mk(0, 1, 16'h0000, 1, 1, 16'h0011, 0));
    tbl.push_back(mk(0, 1, 16'h0000, 1, 0, 16'h0010, 0));
    tbl.push_back(mk(0, 1, 16'h0000, 1, 0, 16'h0009, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 1, 16'h0, 0, 0, 16'h0009, 0));

    foreach (tbl[i]) begin
      cyc(tbl[i].cl, tbl[i].ld, tbl[i].d,
          tbl[i].e, tbl[i].u);
      chk($sformatf("tbl%0d.count", i),
          32'(c0), 32'(tbl[i].exp));
      chk($sformatf("tbl%0d.done", i),
          32'(dn[0]), 32'(tbl[i].exp_done));
    end
    chk("reset.tc_down", 32'(tcs[0]), 32'(0));

    // 01:00 down to 00:00 with a single done pulse.
    cyc(0, 0, 16'h0100, 0, 0);
    cyc(0, 1, 16'h0, 1, 0);
    chk("dn.first", 32'(c0), 32'h0059);
    for (int i = 0; i < 58; i++) begin
      cyc(0, 1, 16'h0, 1, 0);
      chk("dn.nodone", 32'(dn[0]), 32'(0));
    end
    chk("dn.at1", 32'(c0), 32'h0001);
    cyc(0, 1, 16'h0, 1, 0);
    chk("dn.zero", 32'(c0), 32'h0000);
    chk("dn.done", 32'(dn[0]), 32'(1));
    cyc(0, 1, 16'h0, 1, 0);
    chk("dn.hold", 32'(c0), 32'h0000);
    chk("dn.done_clr", 32'(dn[0]), 32'(0));

    // Wrap from 59:59 to 00:00 in the wrapping chain.
    cyc(0, 0, 16'h5959, 0, 1);
    chk("wr.load_done", 32'(dn[1]), 32'(0));
    cyc(0, 1, 16'h0, 1, 1);
    chk("wr.count", 32'(c1), 32'h0000);
    chk("wr.done", 32'(dn[1]), 32'(1));
    chk("wr.stop", 32'(c0), 32'h5959);
    cyc(0, 1, 16'h0, 1, 1);
    chk("wr.next", 32'(c1), 32'h0001);
    chk("wr.done_clr", 32'(dn[1]), 32'(0));

    // Two-digit decimal: 00 up to 99 then hold.
    cyc(1, 1, 16'h0, 0, 1);
    for (int i = 0; i < 99; i++)
      cyc(0, 1, 16'h0, 1, 1);
    chk("dec.99", 32'(c2), 32'h99);
    chk("dec.done", 32'(dn[2]), 32'(1));
    cyc(0, 1, 16'h0, 1, 1);
    chk("dec.hold", 32'(c2), 32'h99);
    chk("dec.done_clr", 32'(dn[2]), 32'(0));

    // Randomised traffic against the model.
    begin
      bit u = 1'b0;
      for (int i = 0; i < 600; i++) begin
        bit cl = ($urandom_range(0, 60) == 0);
        bit ld = ($urandom_range(0, 12) != 0);
        bit e  = ($urandom_range(0, 9) < 8);
        if ($urandom_range(0, 25) == 0) u = ~u;
        cyc(cl, ld, 16'($urandom), e, u);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
